// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and its environment (PLL lock, software
// restart in; staged resets and status out).
interface reset_sequencer_if #(
   parameter int N_STAGES = 3
);
   logic                iLOCK;
   logic                iSW_RST;
   logic [N_STAGES-1:0] oRSTN_STAGE;
   logic                oRD_RST;
   logic                oRST;
   logic                oDONE;
   logic                oLOCK_TO;

   modport master (
      output iLOCK, iSW_RST,
      input  oRSTN_STAGE, oRD_RST, oRST, oDONE, oLOCK_TO
   );

   modport slave (
      input  iLOCK, iSW_RST,
      output oRSTN_STAGE, oRD_RST, oRST, oDONE, oLOCK_TO
   );
endinterface

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: releases staged resets in threshold order once the PLL is locked.
// Define RSTSEQ_WDOG_EN to add the sticky lock-timeout watchdog on oLOCK_TO.
module reset_sequencer #(
   parameter int                        CNT_W     = 27,
   parameter int                        N_STAGES  = 3,
   parameter logic [N_STAGES*CNT_W-1:0] STAGE_THR = {27'd67108864, 27'd33554432, 27'd1048576},
   parameter logic [CNT_W-1:0]          TERM_CNT  = 27'd67108864,
   parameter logic [CNT_W-1:0]          RD_LO     = 27'd33554432,
   parameter logic [CNT_W-1:0]          RD_HI     = 27'd67108864,
   parameter logic [23:0]               WDOG_CYC  = 24'd5000000
) (
   input  logic              iCLK,
   input  logic              iRSTN,
   reset_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {WAIT_LOCK, COUNT, DONE} state_t;

   logic [1:0]          rstSync;
   logic [1:0]          lockSync;
   logic                rstnInt;
   logic                lockS;
   logic                restart;
   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cntInc;
   logic [N_STAGES-1:0] stageRstn;
   logic                rdRst;
   logic                rstOut;
   logic                doneOut;

   // NOTE: reset asserts asynchronously but releases through two flops, so every
   // downstream flop leaves reset on a clean edge.
   always_ff @(posedge iCLK or negedge iRSTN) begin
      if (!iRSTN) begin
         rstSync  <= '0;
         lockSync <= '0;
      end else begin
         rstSync  <= {rstSync[0], 1'b1};
         lockSync <= {lockSync[0], bus.iLOCK};
      end
   end

   assign rstnInt = rstSync[1];
   assign lockS   = lockSync[1];
   assign restart = bus.iSW_RST || !lockS;
   assign cntInc  = cnt + CNT_W'(1);

   always_ff @(posedge iCLK or negedge rstnInt) begin
      if (!rstnInt) begin
         state     <= WAIT_LOCK;
         cnt       <= '0;
         stageRstn <= '0;
         rdRst     <= 1'b0;
         rstOut    <= 1'b1;
         doneOut   <= 1'b0;
      end else begin
         for (int k = 0; k < N_STAGES; k++)
            stageRstn[k] <= (state != WAIT_LOCK) && (cnt >= STAGE_THR[k*CNT_W +: CNT_W]);
         rdRst <= (state != WAIT_LOCK) && (cnt >= RD_LO) && (cnt < RD_HI);

         // Lock loss or software request abandons the sequence from any running state.
         if (state != WAIT_LOCK && restart) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            rstOut  <= 1'b1;
            doneOut <= 1'b0;
         end else begin
            unique case (state)
               WAIT_LOCK: begin
                  cnt <= '0;
                  if (lockS && !bus.iSW_RST) state <= COUNT;
               end
               COUNT: begin
                  cnt <= cntInc;
                  if (cntInc == TERM_CNT) begin
                     state   <= DONE;
                     rstOut  <= 1'b0;
                     doneOut <= 1'b1;
                  end
               end
               DONE:    cnt   <= TERM_CNT;
               default: state <= WAIT_LOCK;
            endcase
         end
      end
   end

   assign bus.oRSTN_STAGE = stageRstn;
   assign bus.oRD_RST     = rdRst;
   assign bus.oRST        = rstOut;
   assign bus.oDONE       = doneOut;

`ifdef RSTSEQ_WDOG_EN
   logic [23:0] wdogCnt;
   logic        lockTo;

   always_ff @(posedge iCLK or negedge rstnInt) begin
      if (!rstnInt) begin
         wdogCnt <= '0;
         lockTo  <= 1'b0;
      end else if (bus.iSW_RST) begin
         wdogCnt <= '0;
         lockTo  <= 1'b0;
      end else if (state == WAIT_LOCK) begin
         if (wdogCnt != WDOG_CYC) wdogCnt <= wdogCnt + 24'd1;
         if (wdogCnt + 24'd1 == WDOG_CYC) lockTo <= 1'b1;
      end else begin
         wdogCnt <= '0;
      end
   end

   assign bus.oLOCK_TO = lockTo;
`else
   assign bus.oLOCK_TO = 1'b0;
`endif

   // Elaboration-constant sanity checks on the configuration, evaluated in simulation.
   generate
      for (genvar k = 0; k < N_STAGES; k++) begin : gThrTerm
         aThrTerm: assert property (@(posedge iCLK) STAGE_THR[k*CNT_W +: CNT_W] <= TERM_CNT);
      end
      for (genvar k = 1; k < N_STAGES; k++) begin : gThrOrder
         aThrOrder: assert property (@(posedge iCLK)
            STAGE_THR[k*CNT_W +: CNT_W] >= STAGE_THR[(k-1)*CNT_W +: CNT_W]);
      end
   endgenerate

   aRdWindow: assert property (@(posedge iCLK) RD_LO <= RD_HI);
   aTermCnt:  assert property (@(posedge iCLK) TERM_CNT >= CNT_W'(1));
   aWdogCyc:  assert property (@(posedge iCLK) WDOG_CYC != 24'd0);
endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed timing points plus randomized lock/restart
// traffic compared against a cycle-level progress model.
`timescale 1ns/1ps
module tb_reset_sequencer;
   localparam int CNT_W    = 8;
   localparam int N_STAGES = 3;
   localparam int TERM     = 40;
   localparam int RD_LO    = 20;
   localparam int RD_HI    = 40;
   localparam int WDOG     = 16;
`ifdef RSTSEQ_WDOG_EN
   localparam bit WDOG_ON = 1'b1;
`else
   localparam bit WDOG_ON = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   thr [N_STAGES] = '{10, 20, 40};

   reset_sequencer_if #(.N_STAGES(N_STAGES)) bus ();

   reset_sequencer #(
      .CNT_W     (CNT_W),
      .N_STAGES  (N_STAGES),
      .STAGE_THR ({8'd40, 8'd20, 8'd10}),
      .TERM_CNT  (8'd40),
      .RD_LO     (8'd20),
      .RD_HI     (8'd40),
      .WDOG_CYC  (24'd16)
   ) dut (
      .iCLK  (clk),
      .iRSTN (rstn),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: prog = cycles since the sequence (re)started, -1 while waiting for lock.
   int                  relCnt = 0;
   int                  prog   = -1;
   int                  wd     = 0;
   bit                  lto    = 1'b0;
   bit                  l1     = 1'b0;
   bit                  l2     = 1'b0;
   logic [N_STAGES-1:0] expStage = '0;
   logic                expRd    = 1'b0;
   logic                expRst   = 1'b1;
   logic                expDone  = 1'b0;
   logic                expLto   = 1'b0;

   always @(posedge clk or negedge rstn) begin : model
      bit lockS;
      int prevProg;
      if (!rstn) begin
         relCnt = 0; prog = -1; wd = 0; lto = 1'b0; l1 = 1'b0; l2 = 1'b0;
         expStage = '0; expRd = 1'b0; expRst = 1'b1; expDone = 1'b0; expLto = 1'b0;
      end else begin
         lockS    = l2;
         l2       = l1;
         l1       = bus.iLOCK;
         prevProg = prog;
         if (relCnt < 2) begin
            relCnt++;
            prog = -1; prevProg = -1; wd = 0; lto = 1'b0;
         end else begin
            if (bus.iSW_RST) begin
               wd = 0; lto = 1'b0;
            end else if (prog < 0) begin
               wd++;
               if (wd == WDOG) lto = 1'b1;
            end else begin
               wd = 0;
            end
            if (bus.iSW_RST || !lockS) prog = -1;
            else if (prog < 0)         prog = 0;
            else if (prog < TERM)      prog++;
         end
         expStage = '0;
         for (int k = 0; k < N_STAGES; k++)
            if (prevProg >= 0 && prevProg >= thr[k]) expStage[k] = 1'b1;
         expRd   = (prevProg >= 0) && (prevProg >= RD_LO) && (prevProg < RD_HI);
         expDone = (prog == TERM);
         expRst  = !expDone;
         expLto  = WDOG_ON && lto;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("rstn_stage", 32'(bus.oRSTN_STAGE), 32'(expStage));
      check("rd_rst",     32'(bus.oRD_RST),     32'(expRd));
      check("rst",        32'(bus.oRST),        32'(expRst));
      check("done",       32'(bus.oDONE),       32'(expDone));
      check("lock_to",    32'(bus.oLOCK_TO),    32'(expLto));
   endtask

   // Advance n active edges, comparing against the model at each following falling edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         compare_all();
      end
   endtask

   task automatic wait_prog(input int target);
      for (int i = 0; i < 200 && prog != target; i++) tick(1);
      check("reach_prog", 32'(prog), 32'(target));
   endtask

   task automatic restart_from_reset(input logic lock, input logic sw);
      @(negedge clk);
      rstn = 1'b0;
      bus.iLOCK = lock;
      bus.iSW_RST = sw;
      @(negedge clk);
      compare_all();
      rstn = 1'b1;
   endtask

   initial begin
      bus.iLOCK   = 1'b1;
      bus.iSW_RST = 1'b0;
      repeat (3) @(negedge clk);
      compare_all();
      check("reset_rst", 32'(bus.oRST), 32'd1);

      // Release just after edge 0; stage/window/done edges follow from the thresholds.
      rstn = 1'b1;
      tick(13); check("stage0_e13", 32'(bus.oRSTN_STAGE[0]), 32'd0);
      tick(1);  check("stage0_e14", 32'(bus.oRSTN_STAGE[0]), 32'd1);
      tick(9);  check("rd_e23",     32'(bus.oRD_RST), 32'd0);
                check("stage1_e23", 32'(bus.oRSTN_STAGE[1]), 32'd0);
      tick(1);  check("rd_e24",     32'(bus.oRD_RST), 32'd1);
                check("stage1_e24", 32'(bus.oRSTN_STAGE[1]), 32'd1);
      tick(18); check("done_e42",   32'(bus.oDONE), 32'd0);
      tick(1);  check("done_e43",   32'(bus.oDONE), 32'd1);
                check("rst_e43",    32'(bus.oRST), 32'd0);
                check("rd_e43",     32'(bus.oRD_RST), 32'd1);
                check("stage2_e43", 32'(bus.oRSTN_STAGE[2]), 32'd0);
      tick(1);  check("stage2_e44", 32'(bus.oRSTN_STAGE[2]), 32'd1);
                check("rd_e44",     32'(bus.oRD_RST), 32'd0);

      // Lock loss from DONE, then relock.
      bus.iLOCK = 1'b0;
      tick(4);
      check("lockloss_stage", 32'(bus.oRSTN_STAGE), 32'd0);
      check("lockloss_rst",   32'(bus.oRST), 32'd1);
      bus.iLOCK = 1'b1;
      tick(60);
      check("relock_done", 32'(bus.oDONE), 32'd1);

      // Software restart pulse mid-sequence.
      bus.iSW_RST = 1'b1; tick(1); bus.iSW_RST = 1'b0;
      wait_prog(15);
      bus.iSW_RST = 1'b1; tick(1); bus.iSW_RST = 1'b0;
      check("swrst_stage_hold", 32'(bus.oRSTN_STAGE[0]), 32'd1);
      tick(1);
      check("swrst_stage_clr", 32'(bus.oRSTN_STAGE), 32'd0);
      tick(50);

      // Asynchronous reset mid-count.
      bus.iSW_RST = 1'b1; tick(1); bus.iSW_RST = 1'b0;
      wait_prog(25);
      #2 rstn = 1'b0;
      #1;
      check("async_rst",   32'(bus.oRST), 32'd1);
      check("async_stage", 32'(bus.oRSTN_STAGE), 32'd0);
      compare_all();
      @(negedge clk);
      rstn = 1'b1;
      tick(50);

      // Lock held low: watchdog timeout, then a late lock still sequences.
      restart_from_reset(1'b0, 1'b0);
      tick(17); check("lockto_e17", 32'(bus.oLOCK_TO), 32'd0);
      tick(1);  check("lockto_e18", 32'(bus.oLOCK_TO), 32'(WDOG_ON));
      bus.iLOCK = 1'b1;
      tick(60);
      check("lockto_done",   32'(bus.oDONE), 32'd1);
      check("lockto_sticky", 32'(bus.oLOCK_TO), 32'(WDOG_ON));
      bus.iSW_RST = 1'b1; tick(1); bus.iSW_RST = 1'b0;
      check("lockto_swclr", 32'(bus.oLOCK_TO), 32'd0);
      tick(10);

      // Software restart held from reset with lock present.
      restart_from_reset(1'b1, 1'b1);
      tick(20);
      check("swhold_rst",   32'(bus.oRST), 32'd1);
      check("swhold_stage", 32'(bus.oRSTN_STAGE), 32'd0);
      bus.iSW_RST = 1'b0;
      tick(1);
      check("swdrop_prog", 32'(prog), 32'd0);
      tick(50);

      // Randomized lock drops, restart pulses and asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         if (bus.iLOCK ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 9) == 0))
            bus.iLOCK = ~bus.iLOCK;
         bus.iSW_RST = ($urandom_range(0, 119) == 0);
         if ($urandom_range(0, 599) == 0) begin
            #2 rstn = 1'b0;
            #1 compare_all();
            @(negedge clk);
            rstn = 1'b1;
         end
         tick(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
